// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: APB interconnect for MASTER_PORTS masters and SLAVE_PORTS slaves, round-robin arbitration, one transfer at a time.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_intercon_rr #(
  parameter int MASTER_PORTS   = 2,
  parameter int SLAVE_PORTS    = 5,
  parameter int BUS_WIDTH      = 16,
  parameter int SEL_HI         = 15,
  parameter int SEL_LO         = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]            M_PREADY
);
  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int SW = SEL_HI - SEL_LO + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]                        state;
  logic [GW-1:0]                     grant, last_grant, next_grant;
  logic [SW-1:0]                     idx, req_sel;
  logic [BUS_WIDTH-1:0]              addr, wdata, req_addr, sel_rdata;
  logic                              write, error, req_any, sel_rdy;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] prdata;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Enable from the masters carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  function automatic int rr_pick(input int base, input int k);
    return (base + k >= MASTER_PORTS) ? base + k - MASTER_PORTS : base + k;
  endfunction

  // Walk downward so the closest requester after last_grant is the last writer.
  always_comb begin
    req_any    = 1'b0;
    next_grant = last_grant;
    for (int k = MASTER_PORTS; k >= 1; k--) begin
      if (S_PSELx[rr_pick(int'(last_grant), k)]) begin
        req_any    = 1'b1;
        next_grant = GW'(rr_pick(int'(last_grant), k));
      end
    end
  end

  assign req_addr = S_PADDR[int'(next_grant)*BUS_WIDTH +: BUS_WIDTH];
  assign req_sel  = req_addr[SEL_HI:SEL_LO];

  always_comb begin
    sel_rdy   = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      if (idx == SW'(s)) begin
        sel_rdy   = M_PREADY[s];
        sel_rdata = M_PRDATA[s*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(MASTER_PORTS - 1);
      idx        <= '0;
      addr       <= '0;
      wdata      <= '0;
      write      <= 1'b0;
      error      <= 1'b0;
      prdata     <= '0;
`ifdef APB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            addr       <= req_addr;
            write      <= S_PWRITE[next_grant];
            wdata      <= S_PWDATA[int'(next_grant)*BUS_WIDTH +: BUS_WIDTH];
            idx        <= req_sel;
            if (int'(req_sel) < SLAVE_PORTS) begin
              state <= SETUP;
              error <= 1'b0;
            end else begin
              state <= DONE;
              error <= 1'b1;
              prdata[int'(next_grant)*BUS_WIDTH +: BUS_WIDTH] <= '0;
            end
          end
        end
        SETUP: begin
          state <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        ACCESS: begin
          if (sel_rdy) begin
            state <= DONE;
            error <= 1'b0;
            prdata[int'(grant)*BUS_WIDTH +: BUS_WIDTH] <= write ? '0 : sel_rdata;
          end
`ifdef APB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            error <= 1'b1;
            prdata[int'(grant)*BUS_WIDTH +: BUS_WIDTH] <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_PSELx   = '0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      M_PSELx[s] = ((state == SETUP) || (state == ACCESS)) && (idx == SW'(s));
    end
    for (int m = 0; m < MASTER_PORTS; m++) begin
      S_PREADY[m]  = (state == DONE) && (grant == GW'(m));
      S_PSLVERR[m] = (state == DONE) && (grant == GW'(m)) && error;
    end
  end

  assign M_PENABLE = (state == ACCESS);
  assign M_PADDR   = addr;
  assign M_PWRITE  = write;
  assign M_PWDATA  = wdata;
  assign S_PRDATA  = prdata;
endmodule
